// File: rtl/bp_pkg.sv
// Shared types and encodings for the local-history branch predictor.
package bp_pkg;
  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t PHT_SNT   = 2'b00;
  localparam pht_ctr_t PHT_WNT   = 2'b01;
  localparam pht_ctr_t PHT_WT    = 2'b10;
  localparam pht_ctr_t PHT_ST    = 2'b11;
  localparam pht_ctr_t PHT_RESET = PHT_WNT;
endpackage

// File: rtl/sat_counter2.sv
// Next-state of a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  pht_ctr_t ctr,
  input  logic     taken,
  output pht_ctr_t ctrNext
);

  always_comb begin
    ctrNext = ctr;
    if (taken) begin
      if (ctr != PHT_ST) ctrNext = ctr + 2'd1;
    end else begin
      if (ctr != PHT_SNT) ctrNext = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Local-history branch predictor: per-PC history (BHT) indexing 2-bit counters (PHT).
// Optional resolved/mispredict counters are enabled with BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_HASH_BITS   = 3,
  parameter int PHT_INDEX_BITS = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic [PC_HASH_BITS-1:0]   pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchM,
  input  logic                      actually_takenM,
  input  logic                      predict_resultM,
  input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM
`ifdef BP_STATS_EN
  ,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispredict_cnt
`endif
);

  localparam int BHT_N = 1 << PC_HASH_BITS;
  localparam int PHT_N = 1 << PHT_INDEX_BITS;

  logic [PHT_INDEX_BITS-1:0] bht [BHT_N];
  pht_ctr_t                  pht [PHT_N];
  pht_ctr_t                  phtNext;

  // Fetch-side lookup: purely combinational, sees pre-edge state on a same-entry write.
  assign pc_hashingF   = pcF[PC_HASH_BITS+1:2];
  assign PHT_indexF    = bht[pc_hashingF] ^ pcF[PHT_INDEX_BITS+1:2];
  assign predict_takeF = pht[PHT_indexF][1];

  sat_counter2 uCtr (
    .ctr     (pht[PHT_indexM]),
    .taken   (actually_takenM),
    .ctrNext (phtNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= PHT_RESET;
    end else if (branchM) begin
      pht[PHT_indexM]  <= phtNext;
      bht[pc_hashingM] <= {bht[pc_hashingM][PHT_INDEX_BITS-2:0], actually_takenM};
    end
  end

  logic unusedPcBits;
  assign unusedPcBits = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0]};

`ifdef BP_STATS_EN
  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (branchM) begin
      branch_cnt <= satInc(branch_cnt);
      if (!predict_resultM) mispredict_cnt <= satInc(mispredict_cnt);
    end
  end
`else
  logic unusedPredResult;
  assign unusedPredResult = predict_resultM;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table-level model plus directed literal checks.
module tb_branch_predictor;
  localparam int HB = 3;
  localparam int IB = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   pcF = '0;
  logic          predict_takeF;
  logic [HB-1:0] pc_hashingF;
  logic [IB-1:0] PHT_indexF;
  logic          branchM = 1'b0;
  logic          actually_takenM = 1'b0;
  logic          predict_resultM = 1'b1;
  logic [HB-1:0] pc_hashingM = '0;
  logic [IB-1:0] PHT_indexM = '0;
`ifdef BP_STATS_EN
  logic [31:0]   branch_cnt;
  logic [31:0]   mispredict_cnt;
`endif

  int nChecks = 0;
  int nErrors = 0;

  branch_predictor #(.PC_HASH_BITS(HB), .PHT_INDEX_BITS(IB)) dut (
    .clk             (clk),
    .rst             (rst_n),
    .pcF             (pcF),
    .predict_takeF   (predict_takeF),
    .pc_hashingF     (pc_hashingF),
    .PHT_indexF      (PHT_indexF),
    .branchM         (branchM),
    .actually_takenM (actually_takenM),
    .predict_resultM (predict_resultM),
    .pc_hashingM     (pc_hashingM),
    .PHT_indexM      (PHT_indexM)
`ifdef BP_STATS_EN
    ,
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history as an integer shifted left, counters as clamped integers.
  int mBht [8];
  int mPht [128];
  int mBr;
  int mMis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mBht[i] <= 0;
      for (int i = 0; i < 128; i++) mPht[i] <= 1;
      mBr  <= 0;
      mMis <= 0;
    end else if (branchM) begin
      if (actually_takenM) mPht[PHT_indexM] <= (mPht[PHT_indexM] < 3) ? mPht[PHT_indexM] + 1 : 3;
      else                 mPht[PHT_indexM] <= (mPht[PHT_indexM] > 0) ? mPht[PHT_indexM] - 1 : 0;
      mBht[pc_hashingM] <= (mBht[pc_hashingM] * 2 + (actually_takenM ? 1 : 0)) % 128;
      mBr <= mBr + 1;
      if (!predict_resultM) mMis <= mMis + 1;
    end
  end

  always @(negedge clk) begin
    int h, idx;
    h   = (pcF / 4) % 8;
    idx = (mBht[h] ^ ((pcF / 4) % 128)) % 128;
    check("model_hash", 32'(pc_hashingF), 32'(h));
    check("model_index", 32'(PHT_indexF), 32'(idx));
    check("model_pred", 32'(predict_takeF), (mPht[idx] >= 2) ? 32'd1 : 32'd0);
`ifdef BP_STATS_EN
    check("model_branch_cnt", branch_cnt, 32'(mBr));
    check("model_mispredict_cnt", mispredict_cnt, 32'(mMis));
`endif
  end

  task automatic train(input int h, input int idx, input bit tk, input bit res);
    branchM         = 1'b1;
    pc_hashingM     = HB'(h);
    PHT_indexM      = IB'(idx);
    actually_takenM = tk;
    predict_resultM = res;
    @(posedge clk);
    #1;
    branchM = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    pcF   = 32'h10;
    #2;
    check("reset_hash", 32'(pc_hashingF), 32'h4);
    check("reset_index", 32'(PHT_indexF), 32'd4);
    check("reset_pred", 32'(predict_takeF), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter walk on PHT[4]: 01 -> 10 -> 11 (held) -> 10 -> 01 -> 00 (held).
    train(3, 4, 1, 1);
    #1 check("pht4_first_taken", 32'(predict_takeF), 32'd1);
    repeat (4) train(3, 4, 1, 1);
    train(3, 4, 0, 0);
    #1 check("pht4_st_then_nt", 32'(predict_takeF), 32'd1);
    train(3, 4, 0, 0);
    #1 check("pht4_wnt", 32'(predict_takeF), 32'd0);
    train(3, 4, 0, 1);
    train(3, 4, 0, 1);
    #1 check("pht4_snt_hold", 32'(predict_takeF), 32'd0);
    check("pht4_index_untouched", 32'(PHT_indexF), 32'd4);

    // History of entry 5 becomes 0000101, cancelling pcF[8:2]=5.
    train(5, 100, 1, 1);
    train(5, 100, 0, 1);
    train(5, 100, 1, 1);
    pcF = 32'h14;
    #1;
    check("bht5_hash", 32'(pc_hashingF), 32'h5);
    check("bht5_index", 32'(PHT_indexF), 32'd0);
    check("bht5_pred", 32'(predict_takeF), 32'd0);

    // Same-cycle read/write of PHT[4]: old value before the edge, new after.
    pcF = 32'h10;
    train(0, 4, 1, 1);
    branchM = 1'b1; pc_hashingM = 3'd0; PHT_indexM = 7'd4; actually_takenM = 1'b1;
    #1 check("same_cycle_before", 32'(predict_takeF), 32'd0);
    @(posedge clk);
    #1;
    check("same_cycle_after", 32'(predict_takeF), 32'd1);
    branchM = 1'b0;

`ifdef BP_STATS_EN
    doReset();
    train(1, 10, 1, 1);
    train(2, 11, 0, 0);
    train(1, 10, 1, 1);
    train(2, 11, 1, 0);
    train(3, 12, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("stats_branch", branch_cnt, 32'd5);
    check("stats_mispredict", mispredict_cnt, 32'd2);
    rst_n = 1'b0;
    #1;
    check("stats_branch_rst", branch_cnt, 32'd0);
    check("stats_mispredict_rst", mispredict_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    // Sweep: varied fetch PCs with interleaved training; the model checks every cycle.
    for (int i = 0; i < 80; i++) begin
      pcF = 32'(i * 28 + 32'h400);
      if (i % 4 != 3) train(i % 8, (i * 37) % 128, (i % 3) != 0, (i % 5) != 0);
      else begin
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset mid-operation discards training at once.
    pcF = 32'h1F4;
    train(5, 125, 1, 1);
    train(5, 125, 1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_index", 32'(PHT_indexF), 32'd125);
    check("midrst_hash", 32'(pc_hashingF), 32'd5);
    check("midrst_pred", 32'(predict_takeF), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
